shift_stream_ctrl: RTL and testbench

//  Sequencer for a universal_shift_reg feeding a serial consumer (e.g. pattern_detect_final).

---
 rtl/shift_ctrl_pkg.sv | 16 +
 rtl/shift_stream_ctrl.sv | 107 ++++++++++
 tb/tb_shift_stream_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register stream sequencer:
// shift-register select codes and controller state encoding.
package shift_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

endpackage

// File: rtl/shift_stream_ctrl.sv
// Sequences an external universal shift register: loads each accepted word once,
// then shifts it right NBITS times so pout[0] presents the word LSB-first.
module shift_stream_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NBITS  = DWIDTH,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    input  logic              pause_i,
    input  logic              abort_i,
    output logic [1:0]        sel_o,
    output logic [DWIDTH-1:0] pin_o,
    output logic              bit_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNTW-1:0]   words_o
);

    localparam int CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    if (NBITS < 1 || NBITS > DWIDTH) begin : g_bad_nbits
        $error("shift_stream_ctrl: NBITS must be in 1..DWIDTH");
    end

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] bit_cnt;
    logic          shift_en;
    logic          last_bit;
    logic          abort_clr;
    logic          accept;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        sel_o        = SEL_HOLD;
        word_ready_o = 1'b0;
        bit_valid_o  = 1'b0;
        shift_en     = 1'b0;
        last_bit     = 1'b0;
        case (state)
            IDLE: begin
                word_ready_o = 1'b1;
                if (word_valid_i) next_state = LOAD;
            end
            LOAD: begin
                if (abort_i) begin
                    next_state = IDLE;
                end else begin
                    sel_o      = SEL_LOAD;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                // Abort outranks pause, which outranks normal progress.
                if (abort_i) begin
                    next_state = IDLE;
                end else if (!pause_i) begin
                    sel_o       = SEL_SHR;
                    bit_valid_o = 1'b1;
                    shift_en    = 1'b1;
                    if (bit_cnt == LAST_IDX) begin
                        last_bit     = 1'b1;
                        word_ready_o = 1'b1;
                        next_state   = word_valid_i ? LOAD : IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign abort_clr = abort_i && (state != IDLE);
    assign accept    = word_valid_i && word_ready_o;
    assign busy_o    = (state != IDLE);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            pin_o   <= '0;
            done_o  <= 1'b0;
            words_o <= '0;
        end else begin
            state  <= next_state;
            done_o <= last_bit;
            if (last_bit) words_o <= words_o + 1'b1;
            if (accept) pin_o <= word_i;
            if (abort_clr || last_bit) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_stream_ctrl.sv
// Directed bench for shift_stream_ctrl: a behavioural shift register follows
// sel/pin so the streamed pout[0] bits can be compared with the source word.
module tb_shift_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Full-length instance (NBITS = DWIDTH = 32)
    logic [31:0] word;
    logic        word_valid, pause, abort;
    logic        ready, bv, busy, done;
    logic [1:0]  sel;
    logic [31:0] pin;
    logic [15:0] words;

    // Short-stream instance (NBITS = 8)
    logic [31:0] b_word;
    logic        b_word_valid, b_pause, b_abort;
    logic        b_ready, b_bv, b_busy, b_done;
    logic [1:0]  b_sel;
    logic [31:0] b_pin;
    logic [15:0] b_words;

    shift_stream_ctrl #(.DWIDTH(32), .NBITS(32), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .word_i(word), .word_valid_i(word_valid),
        .word_ready_o(ready), .pause_i(pause), .abort_i(abort), .sel_o(sel),
        .pin_o(pin), .bit_valid_o(bv), .busy_o(busy), .done_o(done), .words_o(words)
    );

    shift_stream_ctrl #(.DWIDTH(32), .NBITS(8), .CNTW(16)) dut8 (
        .clk(clk), .rst(rst), .word_i(b_word), .word_valid_i(b_word_valid),
        .word_ready_o(b_ready), .pause_i(b_pause), .abort_i(b_abort), .sel_o(b_sel),
        .pin_o(b_pin), .bit_valid_o(b_bv), .busy_o(b_busy), .done_o(b_done), .words_o(b_words)
    );

    // External universal shift register with serial inputs tied to 0
    logic [31:0] sr, b_sr;
    always @(posedge clk) begin
        case (sel)
            2'b11:   sr <= pin;
            2'b01:   sr <= {1'b0, sr[31:1]};
            2'b10:   sr <= {sr[30:0], 1'b0};
            default: sr <= sr;
        endcase
        case (b_sel)
            2'b11:   b_sr <= b_pin;
            2'b01:   b_sr <= {1'b0, b_sr[31:1]};
            2'b10:   b_sr <= {b_sr[30:0], 1'b0};
            default: b_sr <= b_sr;
        endcase
    end

    int checks = 0;
    int errors = 0;
    int exp_words = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Streams one word on the 32-bit instance. done_edge is the clock edge,
    // counted from the accept edge, that samples done_o high (-1 if none).
    task automatic run_word(input string tag, input logic [31:0] w, input int pause_at,
                            input int pause_len, input int abort_at,
                            output int done_edge, output int shifts);
        int  e;
        int  nb;
        int  paused;
        bit  fin;
        done_edge = -1; shifts = 0; nb = 0; paused = 0; fin = 0;
        @(negedge clk);
        word = w; word_valid = 1'b1;
        #1 check({tag, " ready_idle"}, ready, 1);
        @(posedge clk);
        e = 0;
        @(negedge clk);
        word_valid = 1'b0; word = '0;
        for (int it = 0; it < 200 && !fin; it++) begin
            pause = (pause_at >= 0 && nb == pause_at && paused < pause_len);
            abort = (abort_at >= 0 && nb == abort_at && busy);
            #1;
            if (e == 0) check({tag, " load_sel"}, sel, 2'b11);
            if (abort) begin
                check({tag, " abort_sel"}, sel, 2'b00);
                check({tag, " abort_ready"}, ready, 0);
                check({tag, " abort_bv"}, bv, 0);
                @(posedge clk);
                @(negedge clk);
                abort = 1'b0;
                #1 check({tag, " abort_idle"}, busy, 0);
                for (int k = 0; k < 3; k++) begin
                    check({tag, " abort_no_done"}, done, 0);
                    @(negedge clk);
                end
                fin = 1;
            end else begin
                if (pause) begin
                    if (paused == 0) begin
                        check({tag, " pause_sel"}, sel, 2'b00);
                        check({tag, " pause_bv"}, bv, 0);
                    end
                    paused++;
                end
                if (bv) begin
                    check({tag, " bit"}, sr[0], w[nb]);
                    if (sel == 2'b01) shifts++;
                    nb++;
                end
                if (done) begin
                    done_edge = e + 1;
                    fin = 1;
                end else begin
                    @(posedge clk);
                    e++;
                    @(negedge clk);
                end
            end
        end
        pause = 1'b0; abort = 1'b0;
        if (!fin) check({tag, " timeout"}, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int de, sh;

    initial begin
        logic [63:0] two;
        logic [7:0]  exp6;
        int          busy_cnt, nb, rdy_cnt, e;
        bit          prev_last, drop;

        rst = 1'b1;
        word = '0; word_valid = 0; pause = 0; abort = 0;
        b_word = '0; b_word_valid = 0; b_pause = 0; b_abort = 0;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst sel", sel, 2'b00);
        check("rst pin", pin, 0);
        check("rst done", done, 0);
        check("rst words", words, 0);
        check("rst ready", ready, 1);
        rst = 1'b0;

        // 1: single unpaused word
        run_word("t1", 32'hFDCA5398, -1, 0, -1, de, sh);
        exp_words++;
        check("t1 shifts", sh, 32);
        check("t1 done_edge", de, 34);
        check("t1 words", words, exp_words);

        // 2: back-to-back words with valid held high
        two = {32'h0000FFFF, 32'hFDCA5398};
        busy_cnt = 0; nb = 0; rdy_cnt = 0; prev_last = 0; drop = 0;
        @(negedge clk);
        word = 32'hFDCA5398; word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word = 32'h0000FFFF;
        for (int it = 0; it < 200; it++) begin
            if (drop) word_valid = 1'b0;
            #1;
            if (!busy) break;
            busy_cnt++;
            if (prev_last) check("t2 load_follows", sel, 2'b11);
            prev_last = 0;
            if (bv) begin
                check("t2 bit", sr[0], two[nb]);
                nb++;
            end
            if (ready) begin
                rdy_cnt++;
                prev_last = 1;
                drop = 1;
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
        exp_words += 2;
        check("t2 busy_cycles", busy_cnt, 66);
        check("t2 ready_last", rdy_cnt, 2);
        check("t2 bits", nb, 64);
        @(negedge clk);
        check("t2 words", words, exp_words);

        // 3: pause for 3 cycles at bit 10
        run_word("t3", 32'hFDCA5398, 10, 3, -1, de, sh);
        exp_words++;
        check("t3 shifts", sh, 32);
        check("t3 done_edge", de, 37);
        check("t3 words", words, exp_words);

        // 4: abort at bit 5, then a fresh word
        run_word("t4", 32'h12345678, -1, 0, 5, de, sh);
        check("t4 no_done", de, -1);
        check("t4 words", words, exp_words);
        run_word("t4b", 32'hA5A50F0F, -1, 0, -1, de, sh);
        exp_words++;
        check("t4b shifts", sh, 32);
        check("t4b done_edge", de, 34);
        check("t4b words", words, exp_words);

        // 5: asynchronous reset mid-SHIFT
        @(negedge clk);
        word = 32'hCAFEBABE; word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5 busy", busy, 0);
        check("t5 sel", sel, 2'b00);
        check("t5 bv", bv, 0);
        check("t5 pin", pin, 0);
        check("t5 words", words, 0);
        check("t5 ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_words = 0;
        run_word("t5b", 32'h80000001, -1, 0, -1, de, sh);
        exp_words++;
        check("t5b shifts", sh, 32);
        check("t5b done_edge", de, 34);
        check("t5b words", words, exp_words);

        // 6: NBITS=8 instance, word 0xA5 streams 1,0,1,0,0,1,0,1
        exp6 = 8'b1010_0101;
        nb = 0; de = -1; e = 0;
        @(negedge clk);
        b_word = 32'h000000A5; b_word_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_word_valid = 1'b0;
        for (int it = 0; it < 50; it++) begin
            #1;
            if (e == 0) check("t6 load_sel", b_sel, 2'b11);
            if (b_bv) begin
                if (nb < 8) check("t6 bit", b_sr[0], exp6[nb]);
                nb++;
            end
            if (b_done) begin
                de = e + 1;
                break;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        check("t6 shifts", nb, 8);
        check("t6 done_edge", de, 10);
        check("t6 words", b_words, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
